system_0_led_sequencer: RTL and testbench



---
 rtl/system_0_led_seq_pkg.sv | 39 +++
 rtl/system_0_led_sequencer_if.sv | 45 ++++
 rtl/system_0_led_pattern_gen.sv | 52 +++++
 rtl/system_0_led_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_system_0_led_sequencer.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/system_0_led_seq_pkg.sv
// -----------------------------------------------------------------------------
// system_0_led_seq_pkg
// Shared definitions for the LED sequencer slice.
// Contents:
//   - CSR word offsets seen on the Avalon-MM slave port
//   - pattern mode encodings (CTRL bits 2:1)
//   - sequencer FSM state type and bounce direction type
//   - width of the STATUS step counter
// -----------------------------------------------------------------------------
package system_0_led_seq_pkg;

   // CSR word offsets
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PERIOD = 2'd1;
   localparam logic [1:0] REG_SEED   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   // Step counter reported in STATUS[31:16]; wraps naturally.
   localparam int STEP_CNT_W = 16;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_ROTATE = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_COUNT  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

endpackage

// File: rtl/system_0_led_sequencer_if.sv
// -----------------------------------------------------------------------------
// system_0_led_sequencer_if
// Bus bundle for the LED sequencer. Carries both Avalon-MM links that the
// sequencer sits between:
//   s_*  CSR slave link from the CPU interconnect
//        s_address[1:0], s_chipselect, s_write_n, s_writedata[31:0] -> sequencer
//        s_readdata[31:0]                                         <- sequencer
//   m_*  master link towards the LED PIO data register
//        m_address[1:0], m_chipselect, m_write_n, m_writedata[31:0] <- sequencer
//        m_waitrequest                                             -> sequencer
// Modports give the sequencer's view of each link:
//   slave  : the CSR port the sequencer exposes
//   master : the write port the sequencer drives
// -----------------------------------------------------------------------------
interface system_0_led_sequencer_if;

   logic [1:0]  s_address;
   logic        s_chipselect;
   logic        s_write_n;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata;

   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic        m_waitrequest;

   modport slave (
      input  s_address,
      input  s_chipselect,
      input  s_write_n,
      input  s_writedata,
      output s_readdata
   );

   modport master (
      output m_address,
      output m_chipselect,
      output m_write_n,
      output m_writedata,
      input  m_waitrequest
   );

endinterface

// File: rtl/system_0_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// system_0_led_pattern_gen
// Combinational next-step pattern and bounce-direction logic.
// Ports:
//   mode         in   pattern mode (static / rotate-left / bounce / up-counter)
//   pattern      in   pattern currently written to the PIO
//   dir          in   current bounce direction
//   seed         in   SEED register (static mode re-reads it every step)
//   next_pattern out  pattern for the next step
//   next_dir     out  bounce direction for the next step
// -----------------------------------------------------------------------------
module system_0_led_pattern_gen
   import system_0_led_seq_pkg::*;
#(
   parameter int LED_W = 8
) (
   input  mode_e            mode,
   input  logic [LED_W-1:0] pattern,
   input  dir_e             dir,
   input  logic [LED_W-1:0] seed,
   output logic [LED_W-1:0] next_pattern,
   output dir_e             next_dir
);

   logic [LED_W-1:0] shifted;

   always_comb begin
      next_pattern = pattern;
      next_dir     = dir;
      shifted      = '0;
      case (mode)
         // Static re-reads SEED so a SEED write shows up at the next step.
         MODE_STATIC: next_pattern = seed;
         MODE_ROTATE: next_pattern = {pattern[LED_W-2:0], pattern[LED_W-1]};
         // Zero-filling shift; turn around once the lit edge reaches the end
         // in the direction of travel, so the end bit is shown exactly once.
         MODE_BOUNCE: begin
            if (dir == DIR_LEFT) begin
               shifted = {pattern[LED_W-2:0], 1'b0};
               if (shifted[LED_W-1]) next_dir = DIR_RIGHT;
            end else begin
               shifted = {1'b0, pattern[LED_W-1:1]};
               if (shifted[0]) next_dir = DIR_LEFT;
            end
            next_pattern = shifted;
         end
         MODE_COUNT:  next_pattern = pattern + LED_W'(1);
         default:     next_pattern = pattern;
      endcase
   end

endmodule

// File: rtl/system_0_led_sequencer.sv
// -----------------------------------------------------------------------------
// system_0_led_sequencer
// Autonomous LED pattern sequencer. Owns the LED PIO data register and
// replays a timed pattern into it, one Avalon-MM write per step.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   csr      slave modport: CSR access from the CPU
//              0 CTRL   [0] enable, [2:1] mode
//              1 PERIOD [PERIOD_W-1:0] step interval in clk cycles (0 acts as 1)
//              2 SEED   [LED_W-1:0] initial / static pattern
//              3 STATUS read-only: [0] busy, [15:8] pattern, [31:16] step count
//            s_readdata is combinational from s_address (zero wait states).
//   pio      master modport: writes {zeros, pattern} to PIO_ADDR, honours
//            m_waitrequest by holding the transfer stable.
// Step timing with no stall: a write lasts one cycle and successive writes
// start max(PERIOD,1)+1 cycles apart.
// -----------------------------------------------------------------------------
module system_0_led_sequencer
   import system_0_led_seq_pkg::*;
#(
   parameter int LED_W    = 8,
   parameter int PERIOD_W = 24,
   parameter int PIO_ADDR = 0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   system_0_led_sequencer_if.slave  csr,
   system_0_led_sequencer_if.master pio
);

   // CSR registers
   logic                  ctrl_en;
   mode_e                 ctrl_mode;
   logic [PERIOD_W-1:0]   period_reg;
   logic [LED_W-1:0]      seed_reg;

   // Sequencer state
   state_e                state;
   logic [LED_W-1:0]      pattern;
   dir_e                  dir;
   logic [STEP_CNT_W-1:0] step_cnt;
   logic [PERIOD_W-1:0]   period_cnt;
   logic                  m_cs;
   logic                  m_wr_n;

   logic                  csr_wr;
   logic                  busy;
   logic [PERIOD_W-1:0]   period_load;
   logic [LED_W-1:0]      next_pattern;
   dir_e                  next_dir;
   logic [31:0]           rdata;

   // Upper write-data bits have no register behind them.
   logic                  unused_wdata;
   assign unused_wdata = ^csr.s_writedata[31:PERIOD_W];

   assign csr_wr = csr.s_chipselect && !csr.s_write_n;
   assign busy   = (state != ST_IDLE);

   // The countdown runs from max(PERIOD,1)-1 down to 0, one value per cycle.
   assign period_load = (period_reg == '0) ? '0 : period_reg - PERIOD_W'(1);

   // ---------------------------------------------------------------------------
   // CSR write path (STATUS is read-only; writes to it are dropped)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_en    <= 1'b0;
         ctrl_mode  <= MODE_STATIC;
         period_reg <= '0;
         seed_reg   <= '0;
      end else if (csr_wr) begin
         case (csr.s_address)
            REG_CTRL: begin
               ctrl_en   <= csr.s_writedata[0];
               ctrl_mode <= mode_e'(csr.s_writedata[2:1]);
            end
            REG_PERIOD: period_reg <= csr.s_writedata[PERIOD_W-1:0];
            REG_SEED:   seed_reg   <= csr.s_writedata[LED_W-1:0];
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // CSR read path
   // ---------------------------------------------------------------------------
   always_comb begin
      rdata = '0;
      case (csr.s_address)
         REG_CTRL: begin
            rdata[0]   = ctrl_en;
            rdata[2:1] = ctrl_mode;
         end
         REG_PERIOD: rdata[PERIOD_W-1:0] = period_reg;
         REG_SEED:   rdata[LED_W-1:0]    = seed_reg;
         REG_STATUS: begin
            rdata[0]        = busy;
            rdata[8 +: LED_W] = pattern;
            rdata[31:16]    = step_cnt;
         end
         default: rdata = '0;
      endcase
   end

   assign csr.s_readdata = rdata;

   // ---------------------------------------------------------------------------
   // Next-step pattern
   // ---------------------------------------------------------------------------
   system_0_led_pattern_gen #(
      .LED_W (LED_W)
   ) u_pattern_gen (
      .mode         (ctrl_mode),
      .pattern      (pattern),
      .dir          (dir),
      .seed         (seed_reg),
      .next_pattern (next_pattern),
      .next_dir     (next_dir)
   );

   // ---------------------------------------------------------------------------
   // Sequencer FSM with registered master strobes
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         pattern    <= '0;
         dir        <= DIR_LEFT;
         step_cnt   <= '0;
         period_cnt <= '0;
         m_cs       <= 1'b0;
         m_wr_n     <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               // Every start reloads SEED, including re-enable after a stop.
               if (ctrl_en) begin
                  pattern <= seed_reg;
                  dir     <= DIR_LEFT;
                  m_cs    <= 1'b1;
                  m_wr_n  <= 1'b0;
                  state   <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               // A stalled transfer is never abandoned, even if enable drops.
               if (!pio.m_waitrequest) begin
                  step_cnt   <= step_cnt + STEP_CNT_W'(1);
                  period_cnt <= period_load;
                  m_cs       <= 1'b0;
                  m_wr_n     <= 1'b1;
                  state      <= ctrl_en ? ST_WAIT : ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (!ctrl_en) begin
                  state <= ST_IDLE;
               end else if (period_cnt == '0) begin
                  pattern <= next_pattern;
                  dir     <= next_dir;
                  m_cs    <= 1'b1;
                  m_wr_n  <= 1'b0;
                  state   <= ST_WRITE;
               end else begin
                  period_cnt <= period_cnt - PERIOD_W'(1);
               end
            end
            default: begin
               state  <= ST_IDLE;
               m_cs   <= 1'b0;
               m_wr_n <= 1'b1;
            end
         endcase
      end
   end

   // Pattern only changes on entry to WRITE, so write data is stable for the
   // whole (possibly stalled) transfer.
   assign pio.m_address    = 2'(PIO_ADDR);
   assign pio.m_chipselect = m_cs;
   assign pio.m_write_n    = m_wr_n;
   assign pio.m_writedata  = 32'(pattern);

endmodule

// File: tb/tb_system_0_led_sequencer.sv
`timescale 1ns/1ps
module tb_system_0_led_sequencer;
   import system_0_led_seq_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   system_0_led_sequencer_if bus();

   system_0_led_sequencer #(
      .LED_W(8), .PERIOD_W(24), .PIO_ADDR(0)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .csr     (bus),
      .pio     (bus)
   );

   typedef struct {
      int data;
      int start;
      int done;
   } wr_t;

   wr_t log_q[$];
   int  cyc = 0;
   int  stab_err = 0;
   int  n_pass = 0;
   int  n_total = 0;
   logic       in_xfer = 1'b0;
   int         cur_start = 0;
   logic [7:0] cur_data = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   // Transfer monitor: one record per completed PIO write.
   always @(negedge clk) begin
      if (!reset_n) begin
         in_xfer <= 1'b0;
      end else if (bus.m_chipselect && !bus.m_write_n) begin
         if (bus.m_writedata[31:8] != 24'h0) stab_err <= stab_err + 1;
         if (in_xfer && bus.m_writedata[7:0] !== cur_data) stab_err <= stab_err + 1;
         if (bus.m_address !== 2'd0) stab_err <= stab_err + 1;
         if (!bus.m_waitrequest) begin
            log_q.push_back('{data:  in_xfer ? int'(cur_data) : int'(bus.m_writedata[7:0]),
                              start: in_xfer ? cur_start : cyc,
                              done:  cyc});
            in_xfer <= 1'b0;
         end else if (!in_xfer) begin
            in_xfer   <= 1'b1;
            cur_start <= cyc;
            cur_data  <= bus.m_writedata[7:0];
         end
      end else begin
         in_xfer <= 1'b0;
      end
   end

   // Reference model of one step: returns {dir_right, pattern}.
   function automatic logic [8:0] model_next(input int mode, input int p, input int right, input int seed);
      int q;
      int r;
      r = right;
      case (mode)
         0: q = seed;
         1: q = ((p * 2) % 256) + (p / 128);
         2: begin
            if (r == 0) begin
               q = (p * 2) % 256;
               if (q >= 128) r = 1;
            end else begin
               q = p / 2;
               if (q % 2 == 1) r = 0;
            end
         end
         default: q = (p + 1) % 256;
      endcase
      model_next = {r[0], q[7:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
      bus.s_address    = a;
      bus.s_writedata  = d;
      bus.s_chipselect = 1'b1;
      bus.s_write_n    = 1'b0;
      tick();
      bus.s_chipselect = 1'b0;
      bus.s_write_n    = 1'b1;
   endtask

   task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
      bus.s_address = a;
      #1;
      d = bus.s_readdata;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.m_waitrequest = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic wait_writes(input int target, input int budget, input bit rnd, output bit timed_out);
      int k;
      k = 0;
      while (log_q.size() < target && k < budget) begin
         if (rnd) bus.m_waitrequest = ($urandom_range(0, 2) == 0);
         tick();
         k++;
      end
      timed_out = (log_q.size() < target);
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      do_reset();
      for (int a = 0; a < 4; a++) begin
         csr_read(2'(a), rd);
         n_total++;
         if (rd !== 32'h0) $display("FAIL reset_reg[%0d]: got %h expected 00000000", a, rd);
         else n_pass++;
      end
      n_total++;
      if (bus.m_chipselect !== 1'b0) $display("FAIL reset_cs: got %b expected 0", bus.m_chipselect);
      else n_pass++;
      n_total++;
      if (bus.m_write_n !== 1'b1) $display("FAIL reset_write_n: got %b expected 1", bus.m_write_n);
      else n_pass++;
      n_total++;
      if (bus.m_writedata !== 32'h0) $display("FAIL reset_wdata: got %h expected 0", bus.m_writedata);
      else n_pass++;
      n_total++;
      if (bus.m_address !== 2'd0) $display("FAIL reset_addr: got %0d expected 0", bus.m_address);
      else n_pass++;
   endtask

   task automatic test_rotate();
      int base;
      bit to;
      int p;
      logic [31:0] rd;
      do_reset();
      base = log_q.size();
      csr_write(REG_SEED, 32'h01);
      csr_write(REG_PERIOD, 32'd3);
      csr_write(REG_CTRL, 32'h3);
      wait_writes(base + 9, 300, 1'b0, to);
      csr_write(REG_CTRL, 32'h2);
      repeat (12) tick();
      n_total++;
      if (to || log_q.size() != base + 9) $display("FAIL rot_count: got %0d expected 9", log_q.size() - base);
      else n_pass++;
      if (!to) begin
         p = 1;
         for (int i = 0; i < 9; i++) begin
            n_total++;
            if (log_q[base+i].data != p) $display("FAIL rot_val[%0d]: got %h expected %h", i, log_q[base+i].data, p);
            else n_pass++;
            if (i > 0) begin
               n_total++;
               if (log_q[base+i].start - log_q[base+i-1].start != 4)
                  $display("FAIL rot_spacing[%0d]: got %0d expected 4", i, log_q[base+i].start - log_q[base+i-1].start);
               else n_pass++;
            end
            p = int'(model_next(1, p, 0, 1) & 9'hFF);
         end
         n_total++;
         if (log_q[base+8].data != 8'h01) $display("FAIL rot_ninth: got %h expected 01", log_q[base+8].data);
         else n_pass++;
      end
      csr_read(REG_STATUS, rd);
      n_total++;
      if (rd !== {16'd9, 8'h01, 8'h00}) $display("FAIL rot_status: got %h expected 00090100", rd);
      else n_pass++;
   endtask

   task automatic test_bounce();
      int base;
      bit to;
      int exp_b[10] = '{8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      do_reset();
      base = log_q.size();
      csr_write(REG_SEED, 32'h40);
      csr_write(REG_PERIOD, 32'd1);
      csr_write(REG_CTRL, 32'h5);
      wait_writes(base + 10, 200, 1'b0, to);
      csr_write(REG_CTRL, 32'h0);
      repeat (6) tick();
      n_total++;
      if (to) $display("FAIL bounce_timeout: got %0d writes expected 10", log_q.size() - base);
      else n_pass++;
      if (!to) begin
         for (int i = 0; i < 10; i++) begin
            n_total++;
            if (log_q[base+i].data != exp_b[i]) $display("FAIL bounce_val[%0d]: got %h expected %h", i, log_q[base+i].data, exp_b[i]);
            else n_pass++;
         end
         n_total++;
         if (log_q[base+9].start - log_q[base+8].start != 2)
            $display("FAIL bounce_spacing: got %0d expected 2", log_q[base+9].start - log_q[base+8].start);
         else n_pass++;
      end
   endtask

   task automatic test_counter_stall();
      int base;
      int k;
      int st0;
      bit to;
      logic [31:0] rd;
      do_reset();
      base = log_q.size();
      st0 = stab_err;
      csr_write(REG_SEED, 32'hFE);
      csr_write(REG_PERIOD, 32'd2);
      csr_write(REG_CTRL, 32'h7);
      wait_writes(base + 1, 100, 1'b0, to);
      bus.m_waitrequest = 1'b1;
      k = 0;
      while (!bus.m_chipselect && k < 50) begin
         tick();
         k++;
      end
      repeat (5) tick();
      bus.m_waitrequest = 1'b0;
      wait_writes(base + 3, 100, 1'b0, to);
      csr_write(REG_CTRL, 32'h6);
      repeat (10) tick();
      n_total++;
      if (to || log_q.size() != base + 3) $display("FAIL cnt_count: got %0d expected 3", log_q.size() - base);
      else n_pass++;
      if (log_q.size() >= base + 3) begin
         n_total++;
         if (log_q[base].data != 8'hFE) $display("FAIL cnt_first: got %h expected fe", log_q[base].data);
         else n_pass++;
         n_total++;
         if (log_q[base+1].data != 8'hFF) $display("FAIL cnt_second: got %h expected ff", log_q[base+1].data);
         else n_pass++;
         n_total++;
         if (log_q[base+1].done - log_q[base+1].start + 1 != 6)
            $display("FAIL cnt_hold: got %0d expected 6", log_q[base+1].done - log_q[base+1].start + 1);
         else n_pass++;
         n_total++;
         if (log_q[base+2].data != 8'h00) $display("FAIL cnt_wrap: got %h expected 00", log_q[base+2].data);
         else n_pass++;
      end
      n_total++;
      if (stab_err != st0) $display("FAIL cnt_stable: got %0d bus errors expected 0", stab_err - st0);
      else n_pass++;
      csr_read(REG_STATUS, rd);
      n_total++;
      if (rd[31:16] !== 16'd3) $display("FAIL cnt_steps: got %0d expected 3", rd[31:16]);
      else n_pass++;
   endtask

   task automatic test_disable_stall();
      int base;
      int k;
      bit to;
      logic [31:0] rd;
      do_reset();
      base = log_q.size();
      csr_write(REG_SEED, 32'h81);
      csr_write(REG_PERIOD, 32'd1);
      csr_write(REG_CTRL, 32'h3);
      wait_writes(base + 1, 100, 1'b0, to);
      bus.m_waitrequest = 1'b1;
      k = 0;
      while (!bus.m_chipselect && k < 50) begin
         tick();
         k++;
      end
      csr_write(REG_CTRL, 32'h2);
      repeat (2) tick();
      n_total++;
      if (bus.m_chipselect !== 1'b1 || bus.m_write_n !== 1'b0)
         $display("FAIL dis_held: got cs=%b wn=%b expected cs=1 wn=0", bus.m_chipselect, bus.m_write_n);
      else n_pass++;
      n_total++;
      if (log_q.size() != base + 1) $display("FAIL dis_pending: got %0d writes expected 1", log_q.size() - base);
      else n_pass++;
      bus.m_waitrequest = 1'b0;
      tick();
      csr_read(REG_STATUS, rd);
      n_total++;
      if (rd[0] !== 1'b0) $display("FAIL dis_busy: got %b expected 0", rd[0]);
      else n_pass++;
      repeat (8) tick();
      n_total++;
      if (log_q.size() != base + 2) $display("FAIL dis_count: got %0d expected 2", log_q.size() - base);
      else n_pass++;
      if (log_q.size() >= base + 2) begin
         n_total++;
         if (log_q[base+1].data != 8'h03) $display("FAIL dis_data: got %h expected 03", log_q[base+1].data);
         else n_pass++;
      end
      csr_write(REG_SEED, 32'h3C);
      csr_write(REG_CTRL, 32'h3);
      wait_writes(base + 3, 100, 1'b0, to);
      n_total++;
      if (to || log_q[base+2].data != 8'h3C)
         $display("FAIL dis_reload: got %h expected 3c", to ? -1 : log_q[base+2].data);
      else n_pass++;
      csr_write(REG_CTRL, 32'h0);
      repeat (6) tick();
   endtask

   task automatic test_period0();
      int base;
      int seed;
      bit to;
      do_reset();
      base = log_q.size();
      seed = $urandom_range(0, 255);
      csr_write(REG_SEED, 32'(seed));
      csr_write(REG_PERIOD, 32'd0);
      csr_write(REG_CTRL, 32'h7);
      wait_writes(base + 5, 100, 1'b0, to);
      csr_write(REG_CTRL, 32'h0);
      repeat (6) tick();
      n_total++;
      if (to) $display("FAIL p0_timeout: got %0d writes expected 5", log_q.size() - base);
      else n_pass++;
      if (!to) begin
         for (int i = 1; i < 5; i++) begin
            n_total++;
            if (log_q[base+i].start - log_q[base+i-1].start != 2 || log_q[base+i].data != (seed + i) % 256)
               $display("FAIL p0_step[%0d]: got gap %0d data %h expected gap 2 data %h", i,
                        log_q[base+i].start - log_q[base+i-1].start, log_q[base+i].data, (seed + i) % 256);
            else n_pass++;
         end
      end
   endtask

   task automatic test_random();
      int base;
      int mode, seed, period, gap, n, p, r, st0;
      bit to;
      logic [8:0] nx;
      logic [31:0] rd;
      for (int it = 0; it < 6; it++) begin
         do_reset();
         base   = log_q.size();
         st0    = stab_err;
         mode   = $urandom_range(0, 3);
         seed   = $urandom_range(0, 255);
         period = $urandom_range(0, 4);
         gap    = (period == 0) ? 1 : period;
         csr_write(REG_SEED, 32'(seed));
         csr_write(REG_PERIOD, 32'(period));
         csr_write(REG_CTRL, 32'((mode << 1) | 1));
         wait_writes(base + 6, 2000, 1'b1, to);
         bus.m_waitrequest = 1'b0;
         csr_write(REG_CTRL, 32'h0);
         repeat (12) tick();
         n = log_q.size() - base;
         n_total++;
         if (to) $display("FAIL rnd_timeout[%0d]: got %0d writes expected 6", it, n);
         else n_pass++;
         p = seed;
         r = 0;
         for (int i = 0; i < n; i++) begin
            n_total++;
            if (log_q[base+i].data != p)
               $display("FAIL rnd_val[%0d.%0d]: got %h expected %h (mode %0d)", it, i, log_q[base+i].data, p, mode);
            else n_pass++;
            if (i > 0) begin
               n_total++;
               if (log_q[base+i].start != log_q[base+i-1].done + gap + 1)
                  $display("FAIL rnd_gap[%0d.%0d]: got start %0d expected %0d", it, i,
                           log_q[base+i].start, log_q[base+i-1].done + gap + 1);
               else n_pass++;
            end
            nx = model_next(mode, p, r, seed);
            p  = int'(nx[7:0]);
            r  = int'(nx[8]);
         end
         csr_read(REG_STATUS, rd);
         n_total++;
         if (rd[31:16] !== 16'(n) || rd[0] !== 1'b0)
            $display("FAIL rnd_status[%0d]: got steps %0d busy %b expected steps %0d busy 0", it, rd[31:16], rd[0], n);
         else n_pass++;
         n_total++;
         if (stab_err != st0) $display("FAIL rnd_stable[%0d]: got %0d bus errors expected 0", it, stab_err - st0);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_write();
      int k;
      logic [31:0] rd;
      do_reset();
      csr_write(REG_SEED, 32'h55);
      csr_write(REG_PERIOD, 32'd5);
      csr_write(REG_CTRL, 32'h3);
      bus.m_waitrequest = 1'b1;
      k = 0;
      while (!bus.m_chipselect && k < 50) begin
         tick();
         k++;
      end
      tick();
      n_total++;
      if (bus.m_chipselect !== 1'b1) $display("FAIL rst_pre_cs: got %b expected 1", bus.m_chipselect);
      else n_pass++;
      reset_n = 1'b0;
      #1;
      n_total++;
      if (bus.m_write_n !== 1'b1 || bus.m_chipselect !== 1'b0 || bus.m_writedata !== 32'h0)
         $display("FAIL rst_async: got cs=%b wn=%b wd=%h expected cs=0 wn=1 wd=0",
                  bus.m_chipselect, bus.m_write_n, bus.m_writedata);
      else n_pass++;
      bus.m_waitrequest = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      for (int a = 0; a < 4; a++) begin
         csr_read(2'(a), rd);
         n_total++;
         if (rd !== 32'h0) $display("FAIL rst_reg[%0d]: got %h expected 00000000", a, rd);
         else n_pass++;
      end
   endtask

   initial begin
      bus.s_address     = 2'd0;
      bus.s_chipselect  = 1'b0;
      bus.s_write_n     = 1'b1;
      bus.s_writedata   = 32'h0;
      bus.m_waitrequest = 1'b0;
      test_reset();
      test_rotate();
      test_bounce();
      test_counter_stall();
      test_disable_stall();
      test_period0();
      test_random();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
